// File: rtl/lz_blank_mask.sv
// rtl/lz_blank_mask.sv - leading-zero blank mask for the scanned display value
// Digit 0 is never blanked so an all-zero value still shows a single 0.

module lz_blank_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] disp,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   blank
);

  logic zero_run;

  // Walk from the most significant digit down; a digit is blanked while
  // every nibble from it upwards is zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (disp[4*i +: 4] == 4'h0);
      blank[i] = blank_lz & zero_run;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multiplexed seven-segment scan controller
// Tear-free display register with guard-blanked digit rotation; digit_code feeds an external decoder.

module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic                    ready,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAXC = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic GUARD = 1'b0;
  localparam logic SHOW  = 1'b1;

  localparam logic [CW-1:0] G_LAST   = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST   = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic                    state;

  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    frame_end;
  logic                    accept;

  assign ready  = !pending;
  assign accept = load && !pending;

  lz_blank_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_blank_mask (
    .disp     (disp),
    .blank_lz (blank_lz),
    .blank    (blank)
  );

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == i[IW-1:0]) begin
        cur_nib   = disp[4*i +: 4];
        cur_blank = blank[i];
      end
    end
  end

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state == SHOW && idx == i[IW-1:0] && !cur_blank) begin
        sel_n[i] = 1'b0;
      end
    end
  end

  assign frame_end = (state == SHOW) && (cnt == S_LAST) && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      state      <= GUARD;
      digit_code <= 4'h0;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      digit_code <= cur_nib;
      digit_sel  <= sel_n;
      frame_done <= frame_end;

      if (state == GUARD) begin
        if (cnt == G_LAST) begin
          state <= SHOW;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == S_LAST) begin
          state <= GUARD;
          cnt   <= '0;
          idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Commit needs pending=1 and accept needs pending=0, so they never collide.
      if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
      if (accept) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - directed self-checking bench for ssd_scan_ctrl
// Four digits, 2 guard + 4 show cycles per slot, 24-cycle frames.

module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        ready;
  logic [3:0]  digit_code;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  logic pend;

  ssd_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SHOW_CYCLES  (4),
    .GUARD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .ready      (ready),
    .digit_code (digit_code),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sel", 32'(digit_sel), 32'hF);
    check("rst_code", 32'(digit_code), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst  = 1'b0;
    pend = 1'b0;
  endtask

  // Runs one full frame from its first edge; exp_disp/exp_blank are the
  // hand-derived committed value and blanked digits for this frame.
  task automatic run_frame(input logic [15:0] exp_disp, input logic [3:0] exp_blank,
                           input int l1, input logic [15:0] v1,
                           input int l2, input logic [15:0] v2);
    for (int k = 1; k <= 24; k++) begin
      int slot;
      int pos;
      logic [3:0] esel;
      logic acc;
      slot  = (k - 1) / 6;
      pos   = (k - 1) % 6;
      load  = (k == l1) || (k == l2);
      value = (k == l1) ? v1 : v2;
      acc   = load && !pend;
      step();
      load = 1'b0;
      if (k == 24) pend = 1'b0;
      if (acc) pend = 1'b1;
      esel = 4'hF;
      if (pos >= 2 && !exp_blank[slot]) esel[slot] = 1'b0;
      check("digit_sel", 32'(digit_sel), 32'(esel));
      check("digit_code", 32'(digit_code), 32'(exp_disp[4*slot +: 4]));
      check("frame_done", 32'(frame_done), 32'(k == 24));
      check("ready", 32'(ready), 32'(!pend));
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    pend     = 1'b0;

    // Plain scan after reset
    do_reset();
    run_frame(16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0);

    // Load A3F1, ignored second load, then load exactly on the commit edge
    do_reset();
    run_frame(16'h0000, 4'b0000, 5, 16'hA3F1, 10, 16'h1234);
    run_frame(16'hA3F1, 4'b0000, 7, 16'h0050, 24, 16'h0000);
    blank_lz = 1'b1;
    run_frame(16'h0050, 4'b1100, 3, 16'h0000, 0, 16'h0);
    run_frame(16'h0000, 4'b1110, 0, 16'h0, 0, 16'h0);
    blank_lz = 1'b0;
    run_frame(16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0);

    // Reset at edge 13 with an update pending
    do_reset();
    step();
    step();
    load  = 1'b1;
    value = 16'h1234;
    step();
    load = 1'b0;
    check("pend_ready", 32'(ready), 32'd0);
    repeat (9) step();
    rst = 1'b1;
    step();
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_sel", 32'(digit_sel), 32'hF);
    check("mid_rst_code", 32'(digit_code), 32'h0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    rst  = 1'b0;
    pend = 1'b0;
    run_frame(16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
